vga_line_fetcher: RTL and testbench

Upstream pixel source for the VGA output stage. It reads a 160x120, 3-bit-per-pixel framebuffer from an external synchronous RAM into a double-buffered line buffer. It replays each framebuffer pixel as a 4x4 block on the 640x480 raster driven by the `hvsync_generator` counters. The pixel and both syncs leave the block delayed by the same fixed amount, so the downstream stage keeps its `pixel`/`hsync_out`/`vsync_out` timing unchanged.

---
 rtl/vga_line_fetcher_if.sv | 19 +
 rtl/vga_line_fetcher.sv | 189 ++++++++++++++++++
 tb/tb_vga_line_fetcher.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_line_fetcher_if.sv
// Framebuffer read bus between the line fetcher and its synchronous RAM.
// mem_rd/mem_addr issue a read; mem_data returns one cycle later.
interface vga_line_fetcher_if;
  logic        mem_rd;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_data
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_data
  );
endinterface

// File: rtl/vga_line_fetcher.sv
// Fetches 160x120x3 framebuffer rows into a double line buffer and replays
// each pixel as a 4x4 block on the 640x480 raster with a 2-cycle pipeline.
// Ports: clk, reset (async, active-high), CounterX/CounterY/inDisplayArea and
// vga_h_sync/vga_v_sync from hvsync_generator, mem (RAM read bus, master),
// pixel/hsync_out/vsync_out (2-cycle delayed), fetch_busy, underrun (sticky).
module vga_line_fetcher #(
  parameter int         FB_W       = 160,
  parameter int         FB_H       = 120,
  parameter logic [9:0] PREFETCH_Y = 10'd520
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [9:0]                 CounterX,
  input  logic [9:0]                 CounterY,
  input  logic                       inDisplayArea,
  input  logic                       vga_h_sync,
  input  logic                       vga_v_sync,
  vga_line_fetcher_if.master         mem,
  output logic [2:0]                 pixel,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       fetch_busy,
  output logic                       underrun
);

  localparam logic [9:0] ACT_Y    = 10'(FB_H * 4);
  localparam logic [9:0] LAST_Y   = 10'(FB_H * 4 - 4);
  localparam logic [7:0] COL_LAST = 8'(FB_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  col_q, col_d;
  logic [6:0]  row_q, row_d;
  logic        tgt_q, tgt_d;
  logic        front_q, front_d;
  logic        under_q, under_d;

  logic        wr_en_q;
  logic [7:0]  wr_col_q;
  logic        wr_buf_q;

  logic [2:0]  s1_pix_q;
  logic        s1_de_q;
  logic        s1_hs_q;
  logic        s1_vs_q;
  logic [2:0]  s2_pix_q;
  logic        s2_hs_q;
  logic        s2_vs_q;

  logic [2:0]  lb0 [FB_W];
  logic [2:0]  lb1 [FB_W];

  logic        boundary;
  logic        swap;
  logic        fetch_nxt;
  logic        fetch_pre;
  logic        start;
  logic        busy;
  logic        rd;
  logic [14:0] base;
  logic [7:0]  rd_addr;
  logic        disp_sel;
  logic [2:0]  rd_val;

  assign boundary  = (CounterX == 10'd0) && (CounterY[1:0] == 2'b00);
  assign swap      = boundary && (CounterY < ACT_Y);
  assign fetch_nxt = boundary && (CounterY < LAST_Y);
  assign fetch_pre = boundary && (CounterY == PREFETCH_Y);
  assign start     = fetch_nxt || fetch_pre;
  assign busy      = (state_q != S_IDLE);
  assign rd        = (state_q == S_FETCH);

  // row*160 as row*128 + row*32
  assign base = {1'b0, row_q, 7'd0} + {3'd0, row_q, 5'd0};

  assign mem.mem_rd   = rd;
  assign mem.mem_addr = rd ? (base + {7'd0, col_q}) : 15'd0;

  assign fetch_busy = busy;
  assign underrun   = under_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    tgt_d   = tgt_q;
    front_d = front_q ^ swap;
    under_d = under_q;
    if (start) begin
      // A start always wins: it aborts any fetch still running.
      state_d = S_FETCH;
      col_d   = 8'd0;
      row_d   = fetch_nxt ? (CounterY[8:2] + 7'd1) : 7'd0;
      tgt_d   = ~front_d;
      if (busy) under_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
        end
        S_FETCH: begin
          if (col_q == COL_LAST) state_d = S_DRAIN;
          else col_d = col_q + 8'd1;
        end
        S_DRAIN: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= 8'd0;
      row_q   <= 7'd0;
      tgt_q   <= 1'b0;
      front_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      tgt_q   <= tgt_d;
      front_q <= front_d;
      under_q <= under_d;
    end
  end

  // Read data lags the strobe by one cycle; carry column and buffer along.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q  <= 1'b0;
      wr_col_q <= 8'd0;
      wr_buf_q <= 1'b0;
    end else begin
      wr_en_q  <= rd;
      wr_col_q <= col_q;
      wr_buf_q <= tgt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_q) begin
      if (wr_buf_q) lb1[wr_col_q] <= mem.mem_data;
      else          lb0[wr_col_q] <= mem.mem_data;
    end
  end

  // Use the post-swap select so the first pixels of a new row come
  // from the buffer that becomes front on this very edge.
  assign rd_addr  = CounterX[9:2];
  assign disp_sel = front_q ^ swap;

  always_comb begin
    rd_val = 3'd0;
    if (rd_addr < 8'(FB_W)) begin
      rd_val = disp_sel ? lb1[rd_addr] : lb0[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_pix_q <= 3'd0;
      s1_de_q  <= 1'b0;
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      s2_pix_q <= 3'd0;
      s2_hs_q  <= 1'b0;
      s2_vs_q  <= 1'b0;
    end else begin
      s1_pix_q <= rd_val;
      s1_de_q  <= inDisplayArea;
      s1_hs_q  <= vga_h_sync;
      s1_vs_q  <= vga_v_sync;
      s2_pix_q <= s1_de_q ? s1_pix_q : 3'd0;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
    end
  end

  assign pixel     = s2_pix_q;
  assign hsync_out = s2_hs_q;
  assign vsync_out = s2_vs_q;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Scoreboard bench for vga_line_fetcher: random compressed raster stimulus
// against a framebuffer-level reference model.
module tb_vga_line_fetcher;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] cx = 10'd1;
  logic [9:0] cy = 10'd100;
  logic       de = 1'b0;
  logic       hs = 1'b0;
  logic       vs = 1'b0;
  logic [2:0] pixel;
  logic       hso;
  logic       vso;
  logic       busy;
  logic       under;

  vga_line_fetcher_if mem ();

  vga_line_fetcher dut (
    .clk           (clk),
    .reset         (reset),
    .CounterX      (cx),
    .CounterY      (cy),
    .inDisplayArea (de),
    .vga_h_sync    (hs),
    .vga_v_sync    (vs),
    .mem           (mem),
    .pixel         (pixel),
    .hsync_out     (hso),
    .vsync_out     (vso),
    .fetch_busy    (busy),
    .underrun      (under)
  );

  always #5 clk = ~clk;

  logic [2:0] fb [0:19199];

  always @(posedge clk) begin
    mem.mem_data <= mem.mem_rd ? fb[mem.mem_addr] : 3'd0;
  end

  typedef struct {
    int         due;
    logic [2:0] pix;
    logic       hs;
    logic       vs;
    bit         chk;
  } pexp_t;

  pexp_t pq[$];
  int    aq[$];
  pexp_t pe;

  int cyc    = 0;
  int errs   = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int st     = -100000;
  int ue     = 32'h7fffffff;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: output for edge N is checked just after edge N.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (pq.size() > 0 && pq[0].due < cyc) void'(pq.pop_front());
      if (mon_en) begin
        if (pq.size() > 0 && pq[0].due == cyc) begin
          pe = pq.pop_front();
          if (pe.chk) chk("pixel", int'(pixel), int'(pe.pix));
          chk("hsync_out", int'(hso), int'(pe.hs));
          chk("vsync_out", int'(vso), int'(pe.vs));
        end
        chk("mem_rd", int'(mem.mem_rd),
            int'(cyc >= st && cyc <= st + 159));
        if (mem.mem_rd)
          chk("mem_addr", int'(mem.mem_addr),
              aq.size() > 0 ? aq.pop_front() : -1);
        chk("fetch_busy", int'(busy),
            int'(cyc >= st && cyc <= st + 160));
        chk("underrun", int'(under), int'(cyc >= ue));
      end
    end
  end

  // One raster cycle: drive inputs and record what the model expects.
  task automatic step(input int x, input int y, input bit d);
    pexp_t e;
    int    row;
    int    s;
    @(negedge clk);
    cx = 10'(x);
    cy = 10'(y);
    de = d;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    row = -1;
    if (x == 0 && (y % 4) == 0) begin
      if (y < 476) row = y / 4 + 1;
      else if (y == 520) row = 0;
    end
    if (row >= 0) begin
      s = cyc + 1;
      if (s <= st + 160 && s < ue) ue = s;
      aq.delete();
      for (int i = 0; i < 160; i++) aq.push_back(row * 160 + i);
      st = s;
    end
    e.due = cyc + 2;
    e.pix = 3'd0;
    if (d) e.pix = fb[(y / 4) * 160 + x / 4];
    e.hs  = hs;
    e.vs  = vs;
    e.chk = 1'b1;
    pq.push_back(e);
  endtask

  // fine=1 walks every X; otherwise one random X per 4-pixel block.
  task automatic drive_line(input int y, input bit fine);
    int x;
    int n;
    bit d;
    n = fine ? 640 : 160;
    for (int k = 0; k < n; k++) begin
      if (fine) x = k;
      else if (k == 0) x = 0;
      else x = 4 * k + int'($urandom_range(0, 3));
      d = (x < 640) && (y < 480) && ($urandom_range(0, 15) != 0);
      step(x, y, d);
    end
    for (int p = 0; p < 10; p++) step(640 + p * 8, y, 1'b0);
  endtask

  task automatic reset_pulse(input bit mid);
    @(posedge clk);
    #3;
    if (mid) chk("rd_before_rst", int'(mem.mem_rd), 1);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_pixel", int'(pixel), 0);
    chk("rst_hsync", int'(hso), 0);
    chk("rst_vsync", int'(vso), 0);
    chk("rst_mem_rd", int'(mem.mem_rd), 0);
    chk("rst_mem_addr", int'(mem.mem_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_underrun", int'(under), 0);
    pq.delete();
    aq.delete();
    st = -100000;
    ue = 32'h7fffffff;
    cx = 10'd1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic frame();
    drive_line(520, 1'b0);
    for (int r = 0; r < 120; r++) begin
      drive_line(4 * r, 1'b0);
      if (r == 1) drive_line(5, 1'b1);
    end
    drive_line(480, 1'b0);
    drive_line(500, 1'b0);
  endtask

  initial begin
    for (int a = 0; a < 19200; a++) fb[a] = 3'(a);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) step(1 + i, 100, 1'b0);
    reset_pulse(1'b0);

    // Row 0 prefetch, then abort one at column 80 with reset.
    drive_line(520, 1'b0);
    step(0, 520, 1'b0);
    for (int i = 1; i <= 80; i++) step(i, 520, 1'b0);
    reset_pulse(1'b1);
    for (int i = 0; i < 8; i++) step(1 + i, 520, 1'b0);

    // Two compressed frames: address pattern, then random image.
    frame();
    for (int a = 0; a < 19200; a++) fb[a] = 3'($urandom_range(0, 7));
    frame();

    // Second start 50 cycles into a fetch.
    step(0, 520, 1'b0);
    for (int i = 1; i < 50; i++) step(i, 520, 1'b0);
    step(0, 8, 1'b0);
    for (int i = 1; i < 300; i++) step(i, 8, 1'b0);
    chk("underrun_sticky", int'(under), 1);
    reset_pulse(1'b0);
    for (int i = 0; i < 6; i++) step(1 + i, 100, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
